// File: rtl/ws_array_ctrl.sv
// Job sequencer for the weight-stationary MAC array: weight preload, activation streaming, result flagging.
// Optional busy-cycle counter port perf_cycles is enabled by defining WS_CTRL_PERF_EN.
module ws_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int VEC_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     keep_wt,
    input  logic [VEC_W-1:0]         num_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     wt_rd_en,
    output logic [$clog2(ROWS)-1:0]  wt_rd_addr,
    output logic                     wt_load,
    output logic                     act_rd_en,
    output logic [VEC_W-1:0]         act_rd_addr,
    output logic                     out_valid,
`ifdef WS_CTRL_PERF_EN
    output logic [31:0]              perf_cycles,
`endif
    output logic [VEC_W-1:0]         out_idx
);

    localparam int AW   = $clog2(ROWS);
    localparam int PH_W = $clog2(ROWS + 1);
    localparam int SK_W = $clog2(ROWS + COLS + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(ROWS);
    localparam logic [SK_W-1:0] SK_MAX  = SK_W'(ROWS + COLS);

    typedef enum logic [2:0] {IDLE, LOAD_WT, STREAM, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [VEC_W-1:0]  n_q, n_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [VEC_W-1:0]  rd_idx_q, rd_idx_d;
    logic [SK_W-1:0]   skew_q, skew_d;
    logic [VEC_W-1:0]  out_idx_q, out_idx_d;
    logic [AW-1:0]     wt_rd_addr_q, wt_rd_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wt_rd_en_q, wt_rd_en_d;
    logic              wt_load_q, wt_load_d;
    logic              act_rd_en_q, act_rd_en_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        ph_d         = ph_q;
        rd_idx_d     = rd_idx_q;
        skew_d       = skew_q;
        out_idx_d    = out_idx_q;
        wt_rd_addr_d = wt_rd_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d      = num_vec;
                    ph_d     = '0;
                    rd_idx_d = '0;
                    skew_d   = '0;
                    if (!keep_wt)             state_d = LOAD_WT;
                    else if (num_vec != '0)   state_d = STREAM;
                    else                      state_d = DONE;
                end
            end
            LOAD_WT: begin
                if (ph_q == PH_LAST) state_d = (n_q != '0) ? STREAM : DONE;
                else                 ph_d    = ph_q + 1'b1;
            end
            STREAM: begin
                if (rd_idx_q == n_q - 1'b1) state_d  = DRAIN;
                else                        rd_idx_d = rd_idx_q + 1'b1;
            end
            DRAIN: begin
                if (out_valid_q && out_idx_q == n_q - 1'b1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // skew counter measures cycles since the first STREAM cycle, saturating at the pipeline depth
        if ((state_q == STREAM || state_q == DRAIN) && skew_q != SK_MAX)
            skew_d = skew_q + 1'b1;

        // outputs are computed for the upcoming cycle so every port comes straight from a flop
        wt_rd_en_d  = (state_d == LOAD_WT) && (ph_d != PH_LAST);
        wt_load_d   = (state_d == LOAD_WT) && (ph_d != '0);
        act_rd_en_d = (state_d == STREAM);
        out_valid_d = (state_d == STREAM || state_d == DRAIN) && (skew_d == SK_MAX);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);

        if (wt_rd_en_d)
            wt_rd_addr_d = AW'(ROWS - 1 - int'(ph_d));
        if (out_valid_d)
            out_idx_d = out_valid_q ? out_idx_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            ph_q         <= '0;
            rd_idx_q     <= '0;
            skew_q       <= '0;
            out_idx_q    <= '0;
            wt_rd_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wt_rd_en_q   <= 1'b0;
            wt_load_q    <= 1'b0;
            act_rd_en_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            ph_q         <= ph_d;
            rd_idx_q     <= rd_idx_d;
            skew_q       <= skew_d;
            out_idx_q    <= out_idx_d;
            wt_rd_addr_q <= wt_rd_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wt_rd_en_q   <= wt_rd_en_d;
            wt_load_q    <= wt_load_d;
            act_rd_en_q  <= act_rd_en_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wt_rd_en    = wt_rd_en_q;
    assign wt_rd_addr  = wt_rd_addr_q;
    assign wt_load     = wt_load_q;
    assign act_rd_en   = act_rd_en_q;
    assign act_rd_addr = rd_idx_q;
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;

`ifdef WS_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start)
            perf_d = '0;
        else if (busy_q && perf_q != '1)
            perf_d = perf_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Directed scoreboard bench for ws_array_ctrl (4x4 array, 16-bit vector count).
// Define WS_CTRL_PERF_EN to also check perf_cycles.
module tb_ws_array_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int VEC_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              keep_wt = 1'b0;
    logic [VEC_W-1:0]  num_vec = '0;
    logic              busy, done, wt_rd_en, wt_load, act_rd_en, out_valid;
    logic [1:0]        wt_rd_addr;
    logic [VEC_W-1:0]  act_rd_addr, out_idx;
`ifdef WS_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       exp_perf = '0;
`endif

    ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .keep_wt     (keep_wt),
        .num_vec     (num_vec),
        .busy        (busy),
        .done        (done),
        .wt_rd_en    (wt_rd_en),
        .wt_rd_addr  (wt_rd_addr),
        .wt_load     (wt_load),
        .act_rd_en   (act_rd_en),
        .act_rd_addr (act_rd_addr),
        .out_valid   (out_valid),
`ifdef WS_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .out_idx     (out_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wt_rd_en;
        logic [1:0]  wt_rd_addr;
        logic        wt_load;
        logic        act_rd_en;
        logic [15:0] act_rd_addr;
        logic        out_valid;
        logic [15:0] out_idx;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    obs_t        sb[$];
    logic [15:0] exp_idx = '0;

    // addresses are only meaningful while their strobe is high
    function automatic obs_t sample();
        obs_t s;
        s.busy        = busy;
        s.done        = done;
        s.wt_rd_en    = wt_rd_en;
        s.wt_rd_addr  = wt_rd_en ? wt_rd_addr : 2'b00;
        s.wt_load     = wt_load;
        s.act_rd_en   = act_rd_en;
        s.act_rd_addr = act_rd_en ? act_rd_addr : 16'h0;
        s.out_valid   = out_valid;
        s.out_idx     = out_idx;
        return s;
    endfunction

    task automatic check(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

`ifdef WS_CTRL_PERF_EN
    task automatic check_perf(input string tag);
        checks++;
        assert (perf_cycles === exp_perf) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, perf_cycles, exp_perf);
        end
    endtask
`endif

    // expected outputs for cycles 1..D+1 after the accepting edge; returns D (the done cycle)
    task automatic build(input int n, input bit keep, output int d);
        int   l, t0, tv;
        obs_t e;
        logic [15:0] idx;
        l   = keep ? 0 : ROWS + 1;
        t0  = l + 1;
        tv  = t0 + ROWS + COLS;
        d   = (n == 0) ? l + 1 : tv + n;
        idx = exp_idx;
        for (int c = 1; c <= d + 1; c++) begin
            e = '0;
            e.busy = (c <= d);
            e.done = (c == d);
            if (!keep && c <= ROWS) begin
                e.wt_rd_en   = 1'b1;
                e.wt_rd_addr = 2'(ROWS - c);
            end
            e.wt_load = !keep && c >= 2 && c <= ROWS + 1;
            if (n > 0 && c >= t0 && c < t0 + n) begin
                e.act_rd_en   = 1'b1;
                e.act_rd_addr = 16'(c - t0);
            end
            if (n > 0 && c >= tv && c < tv + n) begin
                e.out_valid = 1'b1;
                idx = 16'(c - tv);
            end
            e.out_idx = idx;
            sb.push_back(e);
        end
        exp_idx = idx;
    endtask

    task automatic run_job(input int n, input bit keep, input int pulse_at, input int stop_at,
                           input string tag);
        int   d, last;
        obs_t e;
        @(negedge clk);
`ifdef WS_CTRL_PERF_EN
        check_perf({tag, " perf_hold"});
`endif
        start   = 1'b1;
        num_vec = 16'(n);
        keep_wt = keep;
        build(n, keep, d);
        last = (stop_at > 0) ? stop_at - 1 : d + 1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            e = sb.pop_front();
            check($sformatf("%s c%0d", tag, c), sample(), e);
        end
        sb.delete();
`ifdef WS_CTRL_PERF_EN
        if (stop_at == 0) begin
            exp_perf = 32'(d);
            check_perf({tag, " perf_end"});
        end
`endif
    endtask

    initial begin
        int rn;
        bit rk;
        reset   = 1'b0;
        start   = 1'b1;
        keep_wt = 1'b0;
        num_vec = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset c%0d", i), sample(), '0);
        end
        reset = 1'b1;
        start = 1'b0;

        run_job(3, 1'b0, 0, 0, "load_n3");
        run_job(3, 1'b1, 0, 0, "keep_n3");
        run_job(0, 1'b0, 0, 0, "load_n0");
        run_job(0, 1'b1, 0, 0, "keep_n0");
        run_job(1, 1'b1, 0, 0, "keep_n1");

        // start pulse at cycle 8 must be ignored; reset lands in cycle 10
        run_job(3, 1'b0, 8, 10, "abort");
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("reset_async", sample(), '0);
        exp_idx = '0;
`ifdef WS_CTRL_PERF_EN
        exp_perf = '0;
`endif
        @(negedge clk);
        check("reset_held", sample(), '0);
        reset = 1'b1;
        run_job(3, 1'b0, 0, 0, "clean");

        rn = $urandom_range(2, 9);
        rk = 1'($urandom_range(0, 1));
        run_job(rn, rk, 0, 0, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws_array_ctrl.md
# ws_array_ctrl

Sequencer for the weight-stationary MAC array (ROWS × COLS PEs). It runs one job per `start`:
- preloads a weight tile through the vertical weight path;
- streams `num_vec` activation vectors from the activation buffer;
- flags the deskewed accumulation outputs at the array bottom as valid.

It sits between the job issuer and the array, and owns the weight-buffer and activation-buffer read ports plus the global weight-load control.

## Interface
- `ROWS`, default 4: PE rows; weights pass down this many stages.
- `COLS`, default 4: PE columns; sets skew depth.
- `VEC_W`, default 16: width of vector count and indices.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: job request; sampled only in IDLE.
- `keep_wt` in 1: sampled with `start`; 1 = skip the weight load and reuse the resident weights.
- `num_vec` in VEC_W: activation vectors in the job; latched with `start`.
- `busy` out 1: high from the cycle after an accepted `start` through DONE inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `wt_rd_en` out 1: weight-buffer read strobe.
- `wt_rd_addr` out $clog2(ROWS): weight row address.
- `wt_load` out 1: drives every PE's weight-load control.
- `act_rd_en` out 1: activation-buffer read strobe.
- `act_rd_addr` out VEC_W: activation vector index.
- `out_valid` out 1: bottom-of-array result row is valid.
- `out_idx` out VEC_W: index of the result row, 0-based.

## Operation
- States: IDLE, LOAD_WT, STREAM, DRAIN, DONE.
- Reset value of every output is 0; the FSM resets to IDLE.
- IDLE, on `start`=1:
  - latch `num_vec` and `keep_wt`;
  - go to LOAD_WT if `keep_wt`=0;
  - else go to STREAM if N>0;
  - else go to DONE.
- `start` is ignored in all other states. No queuing.
- LOAD_WT lasts ROWS+1 cycles, phase k = 0..ROWS.
  - `wt_rd_en`=1 for k = 0..ROWS-1, with `wt_rd_addr` = ROWS-1-k (last row first, because rows shift downward).
  - `wt_load`=1 for k = 1..ROWS, matching the 1-cycle synchronous buffer read latency.
  - After k=ROWS, go to STREAM if N>0, else go to DONE.
- STREAM lasts N cycles: `act_rd_en`=1 and `act_rd_addr` = 0..N-1, consecutive with no gaps. Then go to DRAIN.
- Result timing: let t0 be the first STREAM cycle. `out_valid`=1 on cycles t0+ROWS+COLS .. t0+ROWS+COLS+N-1, with `out_idx` = 0..N-1 matching. This covers read latency 1, ROWS MAC stages, and COLS-1 output deskew.
- DRAIN exits to DONE on the cycle after `out_valid` with `out_idx`=N-1. STREAM+DRAIN total = ROWS+COLS+N cycles.
- DONE lasts 1 cycle, with `done`=1 and `busy`=1. Then go to IDLE. A new `start` is accepted the following cycle.
- `wt_load` is 0 outside LOAD_WT, so PE weights persist across jobs for `keep_wt`.
- Counters:
  - VEC_W-bit with no wrap: max N = 2^VEC_W-1.
  - The skew delay counter is sized for ROWS+COLS.
  - `out_idx` holds its last value when `out_valid`=0.

## Timing
- All outputs are registered (driven from state/counter flops), so they are glitch-free to the buffers.
- Job cycle count, `start` edge to `done` inclusive:
  - (ROWS+1) + (ROWS+COLS+N) + 1 with `keep_wt`=0;
  - ROWS+COLS+N+1 with `keep_wt`=1;
  - N=0 & `keep_wt`=0: ROWS+2;
  - N=0 & `keep_wt`=1: 1.
- `reset` low mid-job: all outputs go to 0 immediately and the FSM returns to IDLE. The array weights clear on the same reset. No `done` is emitted.
- `start` high continuously: a new job starts on every IDLE cycle, i.e. back-to-back with one IDLE cycle between jobs.

## Configuration
- `WS_CTRL_PERF_EN` defined:
  - adds output `perf_cycles` (32 bits, reset 0), which counts `busy` cycles of the current job;
  - the counter clears on the accepted `start` and holds after DONE until the next accepted `start`;
  - it saturates at 2^32-1.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `start`=1 → all outputs 0, `busy`=0, no `done`.
- ROWS=COLS=4, N=3, `keep_wt`=0, `start` accepted at cycle 0 →
  - `wt_rd_addr` 3,2,1,0 on cycles 1–4;
  - `wt_load` on cycles 2–5;
  - `act_rd_addr` 0,1,2 on cycles 6–8;
  - `out_valid` with idx 0,1,2 on cycles 14–16;
  - `done` on cycle 17; `busy` on cycles 1–17.
- Same job with `keep_wt`=1 → no `wt_rd_en`/`wt_load`; `act_rd_en` cycles 1–3; `out_valid` cycles 9–11; `done` cycle 12. Array results reuse the previous weights.
- N=0: with `keep_wt`=0 → load only, `done` at cycle 6, no `act_rd_en`/`out_valid`. With `keep_wt`=1 → `done` at cycle 1.
- `start` pulsed at cycle 8 of a running job → ignored. Assert `reset` at cycle 10 → outputs 0 at once, IDLE; the next `start` runs a full clean job.
- With `WS_CTRL_PERF_EN`, the 4×4 N=3 job → `perf_cycles`=17 after `done`, and it holds until the next `start`.
